// File: rtl/hpm_sweep_sampler.sv
// hpm_sweep_sampler
// Initiator on the SRAM-like CSR port of the performance-counter block. On a
// periodic timer expiry or a manual start pulse it walks mhpmcounter3 onward,
// reads each counter (two halves when XLEN is 32), optionally writes it back
// to zero, and queues {index, value} records in a small FIFO that drains over
// a valid/ready stream.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   enable_i, period_i    periodic timer control (period 0 disables)
//   start_i               manual sweep trigger
//   clear_on_read_i       zero each counter after it has been read
//   debug_mode_i          freezes the timer (a running sweep continues)
//   addr_o/we_o/wdata_o   CSR request to the counter block
//   rdata_i               CSR read data, combinational on addr_o
//   busy_o                sweep in progress
//   sample_*              FIFO head stream (valid/ready)
//   drop_o                sticky: a sample was lost because the FIFO was full
//   skip_o                pulse: a trigger arrived while busy and was ignored
module hpm_sweep_sampler #(
    parameter int NumCounters = 6,
    parameter int XLEN        = 64,
    parameter int FifoDepth   = 4,
    parameter int PeriodWidth = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           enable_i,
    input  logic [PeriodWidth-1:0]         period_i,
    input  logic                           start_i,
    input  logic                           clear_on_read_i,
    input  logic                           debug_mode_i,
    output logic [11:0]                    addr_o,
    output logic                           we_o,
    output logic [XLEN-1:0]                wdata_o,
    input  logic [XLEN-1:0]                rdata_i,
    output logic                           busy_o,
    output logic                           sample_valid_o,
    output logic [$clog2(NumCounters)-1:0] sample_idx_o,
    output logic [63:0]                    sample_value_o,
    input  logic                           sample_ready_i,
    output logic                           drop_o,
    output logic                           skip_o
);

    localparam int IdxW = $clog2(NumCounters);
    localparam int PtrW = $clog2(FifoDepth);
    localparam logic [11:0] AddrLo = 12'hB03;
    localparam logic [11:0] AddrHi = 12'hB83;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumCounters - 1);
    localparam bit Is32 = (XLEN == 32);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LO  = 3'd1,
        RD_HI  = 3'd2,
        PUSH   = 3'd3,
        CLR_LO = 3'd4,
        CLR_HI = 3'd5
    } state_e;

    function automatic logic [11:0] lo_addr(input logic [IdxW-1:0] k);
        return AddrLo + 12'(k);
    endfunction

    function automatic logic [11:0] hi_addr(input logic [IdxW-1:0] k);
        return AddrHi + 12'(k);
    endfunction

    // ---------------- timer ----------------
    logic [PeriodWidth-1:0] timer_q, timer_d;
    logic                   timer_fire_s;
    logic                   trigger_s;

    // Timer next-state: clear when disabled, hold in debug, reload on expiry.
    always_comb begin
        timer_d      = timer_q;
        timer_fire_s = 1'b0;
        if (!enable_i || (period_i == '0)) begin
            timer_d = '0;
        end else if (debug_mode_i) begin
            timer_d = timer_q;
        end else if (timer_q == '0) begin
            timer_fire_s = 1'b1;
            timer_d      = period_i - PeriodWidth'(1);
        end else begin
            timer_d = timer_q - PeriodWidth'(1);
        end
    end

    // Timer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign trigger_s = timer_fire_s | start_i;

    // ---------------- sweep FSM ----------------
    state_e          state_q;
    logic [IdxW-1:0] k_q;
    logic [63:0]     value_q;
    logic [11:0]     addr_q;
    logic            we_q;
    logic [XLEN-1:0] wdata_q;
    logic            busy_q;
    logic            skip_q;
    logic [63:0]     rdata_ext_s;
    logic            last_s;
    logic [IdxW-1:0] k_inc_s;

    // Zero-extend read data so both XLEN variants share one capture path.
    assign rdata_ext_s = 64'(rdata_i);
    assign last_s      = (k_q == LastIdx);
    assign k_inc_s     = k_q + IdxW'(1);

    // Sweep FSM; CSR outputs are registered from the state being entered so
    // addr_o is stable for the whole cycle in which rdata_i is captured.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            k_q     <= '0;
            value_q <= 64'd0;
            addr_q  <= 12'd0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            wdata_q <= '0;
            skip_q  <= trigger_s && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    we_q <= 1'b0;
                    if (trigger_s) begin
                        state_q <= RD_LO;
                        k_q     <= '0;
                        addr_q  <= AddrLo;
                        busy_q  <= 1'b1;
                    end else begin
                        addr_q  <= 12'd0;
                        busy_q  <= 1'b0;
                    end
                end
                RD_LO: begin
                    // Upper half is zero here; RD_HI fills it for XLEN 32.
                    value_q <= rdata_ext_s;
                    if (Is32) begin
                        state_q <= RD_HI;
                        addr_q  <= hi_addr(k_q);
                    end else begin
                        state_q <= PUSH;
                    end
                end
                RD_HI: begin
                    value_q[63:32] <= rdata_ext_s[31:0];
                    state_q        <= PUSH;
                    addr_q         <= lo_addr(k_q);
                end
                PUSH: begin
                    if (clear_on_read_i) begin
                        state_q <= CLR_LO;
                        addr_q  <= lo_addr(k_q);
                        we_q    <= 1'b1;
                    end else if (last_s) begin
                        state_q <= IDLE;
                        addr_q  <= 12'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RD_LO;
                        k_q     <= k_inc_s;
                        addr_q  <= lo_addr(k_inc_s);
                    end
                end
                CLR_LO: begin
                    if (Is32) begin
                        state_q <= CLR_HI;
                        addr_q  <= hi_addr(k_q);
                    end else if (last_s) begin
                        state_q <= IDLE;
                        addr_q  <= 12'd0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RD_LO;
                        k_q     <= k_inc_s;
                        addr_q  <= lo_addr(k_inc_s);
                        we_q    <= 1'b0;
                    end
                end
                CLR_HI: begin
                    we_q <= 1'b0;
                    if (last_s) begin
                        state_q <= IDLE;
                        addr_q  <= 12'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RD_LO;
                        k_q     <= k_inc_s;
                        addr_q  <= lo_addr(k_inc_s);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    addr_q  <= 12'd0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_o  = addr_q;
    assign we_o    = we_q;
    assign wdata_o = wdata_q;
    assign busy_o  = busy_q;
    assign skip_o  = skip_q;

    // ---------------- sample FIFO ----------------
    logic [IdxW+63:0] mem_q [FifoDepth];
    logic [PtrW:0]    wr_ptr_q;
    logic [PtrW:0]    rd_ptr_q;
    logic             drop_q;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic [IdxW+63:0] head_s;

    // Pointers carry an extra wrap bit to tell full from empty.
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    // Full is judged before this cycle's pop, so a simultaneous pop does not rescue a push.
    assign push_s  = (state_q == PUSH) && !full_s;
    assign pop_s   = !empty_s && sample_ready_i;

    // FIFO pointers and sticky drop flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            if ((state_q == PUSH) && full_s) begin
                drop_q <= 1'b1;
            end else begin
                drop_q <= drop_q;
            end
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= {k_q, value_q};
        end
    end

    assign head_s         = mem_q[rd_ptr_q[PtrW-1:0]];
    assign sample_valid_o = !empty_s;
    assign sample_idx_o   = head_s[IdxW+63:64];
    assign sample_value_o = head_s[63:0];
    assign drop_o         = drop_q;

endmodule

// File: doc/hpm_sweep_sampler.md
Name: hpm_sweep_sampler

Overview:
- Initiator on the SRAM-like CSR port of the performance-counter block (addr/we/wdata out, rdata in); the counter block is the responder.
- Periodically, or on a manual trigger, sweeps all mhpmcounters: reads each, optionally clears it, and pushes {index, value} records into a small FIFO.
- FIFO drains over a valid/ready stream to trace or debug logic, giving software-free counter sampling.

Parameters:
- NumCounters, 6, number of mhpmcounters swept (mhpmcounter3 .. 3+NumCounters-1).
- XLEN, 64, CSR data width; 32 or 64 only.
- FifoDepth, 4, sample FIFO entries; power of two, at least 2.
- PeriodWidth, 32, width of the sweep period register.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  enables the periodic timer.
- period_i  in  PeriodWidth  cycles between sweep starts; 0 disables the timer.
- start_i  in  1  manual sweep trigger pulse.
- clear_on_read_i  in  1  write 0 to each counter after it is read.
- debug_mode_i  in  1  freezes the timer.
- addr_o  out  12  CSR address to the counter block.
- we_o  out  1  CSR write enable.
- wdata_o  out  XLEN  CSR write data.
- rdata_i  in  XLEN  CSR read data; combinational response to addr_o in the same cycle.
- busy_o  out  1  sweep in progress.
- sample_valid_o  out  1  FIFO not empty.
- sample_idx_o  out  $clog2(NumCounters)  counter index k (0 = mhpmcounter3).
- sample_value_o  out  64  counter value.
- sample_ready_i  in  1  consumer accepts the head entry.
- drop_o  out  1  sticky: at least one sample was lost (FIFO full).
- skip_o  out  1  one-cycle pulse: a trigger arrived while busy and was ignored.

Behaviour:
- Reset values:
  - Outputs: addr_o=0, we_o=0, wdata_o=0, busy_o=0, sample_valid_o=0, drop_o=0, skip_o=0.
  - Internal: FIFO empty, timer=0, state IDLE, k=0.
- Timer:
  - Decrements each cycle while enable_i=1, period_i!=0 and debug_mode_i=0.
  - At 0 it generates a trigger and reloads period_i-1. So period_i=1 triggers every cycle; period_i=N triggers every N cycles.
  - enable_i=0 or period_i=0 clears the timer to 0 with no trigger.
- Trigger = timer expiry OR start_i.
  - In IDLE: next state RD_LO, k=0, busy_o=1 from the next cycle.
  - When not IDLE: skip_o=1 for that cycle; the sweep is not restarted.
- FSM states: IDLE, RD_LO, RD_HI, PUSH, CLR_LO, CLR_HI.
  - RD_LO: addr_o=0xB03+k, we_o=0; capture rdata_i into value[XLEN-1:0]. Next state is RD_HI if XLEN==32, else PUSH.
  - RD_HI (XLEN==32 only): addr_o=0xB83+k; capture rdata_i into value[63:32]. For XLEN==32, value[63:32] is cleared at RD_LO. Next PUSH.
  - PUSH:
    - If FIFO not full, write {k, value}; otherwise set drop_o.
    - Next state is CLR_LO if clear_on_read_i, else NEXT.
  - CLR_LO: we_o=1, addr_o=0xB03+k, wdata_o=0. Next state is CLR_HI if XLEN==32, else NEXT.
  - CLR_HI: we_o=1, addr_o=0xB83+k, wdata_o=0. Next NEXT.
  - NEXT (folded into transition): if k==NumCounters-1, go to IDLE and drop busy_o; else k+1 and go to RD_LO.
- Outputs from state:
  - we_o=1 only in CLR_* states.
  - addr_o=0 and wdata_o=0 in IDLE.
- Sweep length:
  - XLEN64, no clear: 2 cycles per counter, so 12 for NumCounters=6.
  - XLEN64 with clear: 3 cycles per counter. XLEN32 with clear: 5 cycles per counter.
- clear_on_read_i is sampled in PUSH, per counter.
- debug_mode_i does not abort a sweep in flight; it only freezes the timer.
- FIFO:
  - Head drives sample_idx_o/sample_value_o; pop when sample_valid_o && sample_ready_i.
  - Full is evaluated on pre-pop state: a push while full is dropped even if a pop occurs the same cycle.
  - Push into empty FIFO: sample_valid_o=1 on the next cycle.
- drop_o clears only on reset.
- Counters are modulo 2^64; no saturation logic in this block.
- Asynchronous reset mid-sweep returns to IDLE immediately, empties the FIFO and deasserts we_o.

Test Plan:
- XLEN=64, start_i pulse, rdata_i=0x100+addr, sample_ready_i=1 -> addresses 0xB03..0xB08 in alternate cycles; 6 samples idx 0..5 with values 0xC03..0xC08; busy_o high exactly 12 cycles.
- period_i=20, enable_i=1 -> sweep starts every 20 cycles; set debug_mode_i for 5 cycles -> next start delayed by exactly 5 cycles.
- clear_on_read_i=1, XLEN=64 -> after each RD cycle, a PUSH cycle, then one cycle we_o=1, wdata_o=0 at the same address; 18-cycle sweep.
- XLEN=32, rdata_i at 0xB03=0x1111_1111 and at 0xB83=0x2222_2222 -> sample idx 0 value 0x2222_2222_1111_1111.
- sample_ready_i=0, FifoDepth=4, full sweep -> 4 samples idx 0..3 retained, drop_o=1; asserting ready then pops idx 0..3 in order.
- start_i asserted during a sweep -> skip_o 1-cycle pulse; sweep length unchanged; reset asserted mid-sweep -> busy_o=0, we_o=0, sample_valid_o=0.
